// File: rtl/apb_master.sv
// apb_master: APB requester that turns a valid/ready host command into a
// single APB transfer (IDLE -> SETUP -> ACCESS) towards one slave.
// It holds ACCESS through slave wait states, captures read data and returns
// a one-cycle response pulse. All outputs come straight from flops.
//
// Optional feature, enabled by defining APB_MASTER_TIMEOUT_EN:
//   an ACCESS wait counter aborts a transfer after TIMEOUT_CYCLES wait edges
//   and reports rsp_error = 1 with rsp_rdata = 0. If PREADY is high on the
//   edge where the limit is reached, the transfer completes normally.
//   Without the macro no counter exists, rsp_error is tied low and ACCESS
//   waits indefinitely.
module apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  READ_WRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  // A zero or negative wait limit would make the timeout meaningless.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
    $error("apb_master: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                  state_q,      state_d;
  logic                    cmd_ready_q,  cmd_ready_d;
  logic                    psel_q,       psel_d;
  logic                    penable_q,    penable_d;
  logic                    rw_q,         rw_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,      paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q,     pwdata_d;
  logic                    rsp_valid_q,  rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q,  rsp_rdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
  // Counter is wide enough to hold TIMEOUT_CYCLES itself.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Count value seen on the edge that would be the TIMEOUT_CYCLES-th wait.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]        wait_cnt_q,   wait_cnt_d;
  logic                    rsp_error_q,  rsp_error_d;
`endif

  // State and output registers, cleared asynchronously by PRESET.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rw_q        <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q  <= '0;
      rsp_error_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rw_q        <= rw_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      rsp_error_q <= rsp_error_d;
`endif
    end
  end

  // Next state plus next values of every registered output; each branch sets
  // the outputs for the state it is heading into, so outputs track state
  // without a combinational path to the pins.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rw_d        = rw_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    rsp_error_d = rsp_error_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          // Latch the command; bus fields stay frozen until the next accept.
          state_d     = ST_SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          rw_d        = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
        end else begin
          state_d     = ST_IDLE;
          cmd_ready_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
        end
      end

      ST_SETUP: begin
        state_d     = ST_ACCESS;
        cmd_ready_d = 1'b0;
        psel_d      = 1'b1;
        penable_d   = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d  = '0;
`endif
      end

      ST_ACCESS: begin
        if (PREADY) begin
          // Completion wins even on the edge where the wait limit is hit.
          state_d     = ST_IDLE;
          cmd_ready_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          if (!rw_q) begin
            rsp_rdata_d = PRDATA;
          end else begin
            rsp_rdata_d = rsp_rdata_q;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_error_d = 1'b0;
`endif
        end else begin
`ifdef APB_MASTER_TIMEOUT_EN
          if (wait_cnt_q == WAIT_LAST) begin
            // Slave never answered: abandon the transfer with an error.
            state_d     = ST_IDLE;
            cmd_ready_d = 1'b1;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_error_d = 1'b1;
            wait_cnt_d  = '0;
          end else begin
            state_d     = ST_ACCESS;
            wait_cnt_d  = wait_cnt_q + CNT_W'(1);
          end
`else
          state_d     = ST_ACCESS;
`endif
        end
      end

      default: begin
        // Unreachable encoding: fall back to a clean idle bus.
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
      end
    endcase
  end

  assign cmd_ready  = cmd_ready_q;
  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign READ_WRITE = rw_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
  assign rsp_error  = rsp_error_q;
`else
  assign rsp_error  = 1'b0;
`endif

endmodule
